player_motion_ctrl: RTL and testbench
=====================================

// Module: player_motion_ctrl
// PURPOSE
//   Downstream of the keyboard direction FSM. Consumes the two requested
//   directions (p1_dir, p2_dir) and advances both player heads one grid cell
//   per game step. Rejects 180-degree reversals, detects wall and head-on
//   collisions, and runs the IDLE/RUN/OVER game sequence.
//   Outputs feed the renderer and the score/display logic.
// PARAMETERS
//   GRID_W    40          grid columns, x in 0..GRID_W-1
//   GRID_H    30          grid rows, y in 0..GRID_H-1 (y=0 is the top row)
//   X_W       6           x coordinate width, must hold GRID_W-1
//   Y_W       5           y coordinate width, must hold GRID_H-1
//   TICK_DIV  25_000_000  clk cycles per game step (>=2)
//   P1_X0/P1_Y0  30/15    player 1 start cell
//   P2_X0/P2_Y0  9/15     player 2 start cell
// PORTS
//   clk       in   1    system clock
//   rst       in   1    synchronous, active-high reset
//   start     in   1    1-cycle pulse: begin or restart a round
//   p1_dir    in   2    requested direction of player 1 (UP/DOWN/RIGHT/LEFT)
//   p2_dir    in   2    requested direction of player 2
//   p1_x,p1_y out  X_W,Y_W  player 1 head cell
//   p2_x,p2_y out  X_W,Y_W  player 2 head cell
//   p1_head,p2_head out 2   applied heading of each player
//   step      out  1    1-cycle pulse in the first cycle new positions are visible
//   running   out  1    high in RUN
//   winner    out  2    00 none/in play, 01 P1 won, 10 P2 won, 11 draw
// BEHAVIOUR
//   - Reset, synchronous, one clock edge: state=IDLE, tick counter=0,
//     heads at P1_X0/P1_Y0 and P2_X0/P2_Y0, p1_head=p2_head=UP,
//     step=0, running=0, winner=00. rst in any state wins over every other input.
//   - Direction encoding: UP=00, DOWN=01, RIGHT=10, LEFT=11.
//     Reverse of d = {d[1], ~d[0]}.
//   - IDLE: counter held at 0. start -> RUN next edge, counter=0.
//   - RUN: counter counts 0..TICK_DIV-1 and wraps. The edge on which the
//     counter is at TICK_DIV-1 is the step edge. On the step edge, per player:
//       heading' = req_dir when req_dir != reverse(heading), else heading.
//       Next cell = cell moved one unit along heading'
//       (UP y-1, DOWN y+1, RIGHT x+1, LEFT x-1).
//   - Wall: next cell outside 0..GRID_W-1 / 0..GRID_H-1, checked before the
//     arithmetic so nothing wraps -> that player is dead.
//   - Head-on: both next cells equal, or the heads swap cells
//     (p1_next==p2_cur && p2_next==p1_cur) -> both players are dead.
//   - A dead player keeps its pre-step cell; its heading is still updated.
//     A living player moves to its next cell.
//   - Any death -> OVER on the same edge.
//     winner = {p1_alive & ~p2_alive ? 01 : ~p1_alive & p2_alive ? 10 : 11}.
//   - step is registered: high for exactly one cycle after each step edge,
//     including the fatal step. Requested direction is sampled only on step
//     edges, so changes between steps are ignored except the last value seen.
//   - start during RUN is ignored.
//   - OVER: positions, headings and winner frozen; counter held at 0.
//     start -> reinitialise positions/headings, winner=00, then RUN.
//   - start on the same edge as the IDLE->RUN transition's first count:
//     no step is issued until TICK_DIV cycles have elapsed.
// STRUCTURE
//   - Shared package/header (global.v): direction codes UP/DOWN/RIGHT/LEFT,
//     winner codes, state codes IDLE/RUN/OVER.
//   - One sub-module: step_timer (counter with enable and clear, emits a
//     terminal-count pulse). Top level holds the FSM, the per-player
//     next-cell/wall logic, and the collision compare.
// TESTING (bench uses TICK_DIV=4, GRID 40x30, defaults otherwise)
//   - rst high 1 cycle -> p1=(30,15), p2=(9,15), heads UP, running=0,
//     winner=00, no step while in IDLE.
//   - start; p1_dir=LEFT, p2_dir=RIGHT held -> step every 4 cycles;
//     after 1st step p1=(29,15), p2=(10,15).
//   - p1 heading UP, p1_dir=DOWN -> reversal rejected, p1_head stays UP,
//     y decrements by 1 per step.
//   - p2 driven LEFT from (9,15) -> after 9 steps x=0; 10th step -> x stays 0,
//     winner=01, running=0, positions frozen.
//   - heads converge on the same row: equal-next and swap cases -> winner=11,
//     both heads keep pre-step cells.
//   - rst asserted mid-RUN between steps -> full reset values next edge;
//     start in OVER -> start cells restored and stepping resumes.

Source files
------------

// File: rtl/player_motion_ctrl_pkg.sv
// Shared codes for the player motion controller: directions, game states, winner codes.
package player_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Opposite direction: flipping bit 0 swaps UP/DOWN and RIGHT/LEFT.
  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/player_motion_ctrl_step_timer.sv
// Game-step divider: counts 0..TICK_DIV-1 while enabled, flags the terminal count.
module player_motion_ctrl_step_timer #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Two-player grid motion controller: step timing, reversal filter, wall and
// head-on collision detection, IDLE/RUN/OVER game sequencing.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned X_W      = 6,
  parameter int unsigned Y_W      = 5,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned P1_X0    = 30,
  parameter int unsigned P1_Y0    = 15,
  parameter int unsigned P2_X0    = 9,
  parameter int unsigned P2_Y0    = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     p1_dir,
  input  logic [1:0]     p2_dir,
  output logic [X_W-1:0] p1_x,
  output logic [Y_W-1:0] p1_y,
  output logic [X_W-1:0] p2_x,
  output logic [Y_W-1:0] p2_y,
  output logic [1:0]     p1_head,
  output logic [1:0]     p2_head,
  output logic           step,
  output logic           running,
  output logic [1:0]     winner
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q [2];
  logic [X_W-1:0] x_d [2];
  logic [Y_W-1:0] y_q [2];
  logic [Y_W-1:0] y_d [2];
  dir_e           head_q [2];
  dir_e           head_d [2];
  logic           step_q, step_d;
  logic           running_q, running_d;
  logic [1:0]     winner_q, winner_d;

  dir_e           req [2];
  dir_e           head_n [2];
  logic [X_W-1:0] nx [2];
  logic [Y_W-1:0] ny [2];
  logic           wall [2];
  logic           alive [2];
  logic           headon_c;
  logic           tick_c;

  player_motion_ctrl_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .clr  (state_q != ST_RUN),
    .tc_c (tick_c)
  );

  // Per-player heading filter and next cell; wall checked before any arithmetic.
  always_comb begin
    req[0] = dir_e'(p1_dir);
    req[1] = dir_e'(p2_dir);
    for (int i = 0; i < 2; i++) begin
      head_n[i] = (req[i] != dir_reverse(head_q[i])) ? req[i] : head_q[i];
      nx[i]     = x_q[i];
      ny[i]     = y_q[i];
      wall[i]   = 1'b0;
      case (head_n[i])
        DIR_UP:    if (y_q[i] == '0)   wall[i] = 1'b1; else ny[i] = y_q[i] - Y_W'(1);
        DIR_DOWN:  if (y_q[i] == Y_MAX) wall[i] = 1'b1; else ny[i] = y_q[i] + Y_W'(1);
        DIR_RIGHT: if (x_q[i] == X_MAX) wall[i] = 1'b1; else nx[i] = x_q[i] + X_W'(1);
        DIR_LEFT:  if (x_q[i] == '0)   wall[i] = 1'b1; else nx[i] = x_q[i] - X_W'(1);
        default:   wall[i] = 1'b0;
      endcase
    end
  end

  // Head-on: both land on one cell, or the two heads trade places.
  always_comb begin
    headon_c = !wall[0] && !wall[1] &&
               (((nx[0] == nx[1]) && (ny[0] == ny[1])) ||
                ((nx[0] == x_q[1]) && (ny[0] == y_q[1]) &&
                 (nx[1] == x_q[0]) && (ny[1] == y_q[0])));
    alive[0] = !wall[0] && !headon_c;
    alive[1] = !wall[1] && !headon_c;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    head_d    = head_q;
    step_d    = 1'b0;
    running_d = running_q;
    winner_d  = winner_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_RUN;
          x_d[0]    = X_W'(P1_X0);
          y_d[0]    = Y_W'(P1_Y0);
          x_d[1]    = X_W'(P2_X0);
          y_d[1]    = Y_W'(P2_Y0);
          head_d[0] = DIR_UP;
          head_d[1] = DIR_UP;
          running_d = 1'b1;
          winner_d  = WIN_NONE;
        end
      end
      ST_RUN: begin
        if (tick_c) begin
          step_d = 1'b1;
          for (int i = 0; i < 2; i++) begin
            head_d[i] = head_n[i];
            if (alive[i]) begin
              x_d[i] = nx[i];
              y_d[i] = ny[i];
            end
          end
          if (!alive[0] || !alive[1]) begin
            state_d   = ST_OVER;
            running_d = 1'b0;
            case ({alive[0], alive[1]})
              2'b10:   winner_d = WIN_P1;
              2'b01:   winner_d = WIN_P2;
              default: winner_d = WIN_DRAW;
            endcase
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q[0]    <= X_W'(P1_X0);
      y_q[0]    <= Y_W'(P1_Y0);
      x_q[1]    <= X_W'(P2_X0);
      y_q[1]    <= Y_W'(P2_Y0);
      head_q[0] <= DIR_UP;
      head_q[1] <= DIR_UP;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      head_q    <= head_d;
      step_q    <= step_d;
      running_q <= running_d;
      winner_q  <= winner_d;
    end
  end

  assign p1_x    = x_q[0];
  assign p1_y    = y_q[0];
  assign p2_x    = x_q[1];
  assign p2_y    = y_q[1];
  assign p1_head = head_q[0];
  assign p2_head = head_q[1];
  assign step    = step_q;
  assign running = running_q;
  assign winner  = winner_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with TICK_DIV=4; a second instance with
// P2 starting at x=10 reaches the equal-next-cell draw.
module tb_player_motion_ctrl;

  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, RIGHT = 2'b10, LEFT = 2'b11;

  logic       clk = 1'b0;
  logic       rst, rst2, start;
  logic [1:0] p1_dir, p2_dir;

  logic [5:0] p1_x, p2_x, q1_x, q2_x;
  logic [4:0] p1_y, p2_y, q1_y, q2_y;
  logic [1:0] p1_head, p2_head, q1_head, q2_head;
  logic       step, running, q_step, q_running;
  logic [1:0] winner, q_winner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  player_motion_ctrl #(.TICK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_head(p1_head), .p2_head(p2_head),
    .step(step), .running(running), .winner(winner)
  );

  player_motion_ctrl #(.TICK_DIV(4), .P2_X0(10)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .p1_x(q1_x), .p1_y(q1_y), .p2_x(q2_x), .p2_y(q2_y),
    .p1_head(q1_head), .p2_head(q2_head),
    .step(q_step), .running(q_running), .winner(q_winner)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the step pulse is seen; bounded so a dead timer cannot hang.
  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!step && cycles < 16);
    check("step_seen", int'(step), 1);
  endtask

  task automatic check_start_cells(input string tag);
    check({tag, "_p1_x"}, int'(p1_x), 30);
    check({tag, "_p1_y"}, int'(p1_y), 15);
    check({tag, "_p2_x"}, int'(p2_x), 9);
    check({tag, "_p2_y"}, int'(p2_y), 15);
    check({tag, "_p1_head"}, int'(p1_head), int'(UP));
    check({tag, "_p2_head"}, int'(p2_head), int'(UP));
    check({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; p1_dir = UP; p2_dir = UP;
    tick(); tick();
    rst = 1'b0;

    check_start_cells("rst");
    check("rst_running", int'(running), 0);
    check("rst_step", int'(step), 0);
    seen = 0;
    repeat (8) begin tick(); seen |= int'(step); end
    check("idle_no_step", seen, 0);
    check("idle_running", int'(running), 0);

    // First round: heads move toward each other, first step after TICK_DIV cycles.
    p1_dir = LEFT; p2_dir = RIGHT; start = 1'b1;
    tick();
    start = 1'b0;
    check("run_running", int'(running), 1);
    wait_step(n);
    check("first_step_latency", n, 4);
    check("s1_p1_x", int'(p1_x), 29);
    check("s1_p1_y", int'(p1_y), 15);
    check("s1_p2_x", int'(p2_x), 10);
    check("s1_p1_head", int'(p1_head), int'(LEFT));
    check("s1_p2_head", int'(p2_head), int'(RIGHT));
    tick();
    check("step_one_cycle", int'(step), 0);

    // Turn p1 UP, then request DOWN: reversal must be rejected.
    p1_dir = UP;
    wait_step(n);
    check("up_p1_y", int'(p1_y), 14);
    check("up_p1_head", int'(p1_head), int'(UP));
    p1_dir = DOWN;
    wait_step(n);
    check("step_period", n, 4);
    check("rev_p1_head", int'(p1_head), int'(UP));
    check("rev_p1_y", int'(p1_y), 13);
    p1_dir = RIGHT;
    tick(); tick();
    p1_dir = DOWN;
    wait_step(n);
    check("rev2_p1_x", int'(p1_x), 29);
    check("rev2_p1_y", int'(p1_y), 12);
    check("rev2_p2_x", int'(p2_x), 13);

    // Reset between steps.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_start_cells("midrst");
    check("midrst_running", int'(running), 0);
    check("midrst_step", int'(step), 0);

    // P2 runs into the left wall on its 10th step.
    p1_dir = UP; p2_dir = LEFT; start = 1'b1;
    tick();
    start = 1'b0;
    wait_step(n);
    check("wall_first_latency", n, 4);
    repeat (8) wait_step(n);
    check("wall9_p2_x", int'(p2_x), 0);
    check("wall9_p1_y", int'(p1_y), 6);
    check("wall9_running", int'(running), 1);
    check("wall9_winner", int'(winner), 0);
    wait_step(n);
    check("wall_winner", int'(winner), 1);
    check("wall_running", int'(running), 0);
    check("wall_p2_x", int'(p2_x), 0);
    check("wall_p2_y", int'(p2_y), 15);
    check("wall_p2_head", int'(p2_head), int'(LEFT));
    check("wall_p1_x", int'(p1_x), 30);
    check("wall_p1_y", int'(p1_y), 5);
    seen = 0;
    repeat (8) begin tick(); seen |= int'(step); end
    check("over_no_step", seen, 0);
    check("over_p1_y", int'(p1_y), 5);
    check("over_winner", int'(winner), 1);

    // Restart from OVER; both instances converge on row 15.
    p1_dir = LEFT; p2_dir = RIGHT; rst2 = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_start_cells("restart");
    check("restart_running", int'(running), 1);
    check("dut2_running", int'(q_running), 1);
    wait_step(n);
    check("restart_latency", n, 4);
    check("restart_p1_x", int'(p1_x), 29);
    check("restart_p2_x", int'(p2_x), 10);
    repeat (8) wait_step(n);
    check("c9_p1_x", int'(p1_x), 21);
    check("c9_p2_x", int'(p2_x), 18);
    check("c9_q1_x", int'(q1_x), 21);
    check("c9_q2_x", int'(q2_x), 19);
    check("c9_q_winner", int'(q_winner), 0);
    wait_step(n);
    check("eq_q_winner", int'(q_winner), 3);
    check("eq_q_running", int'(q_running), 0);
    check("eq_q1_x", int'(q1_x), 21);
    check("eq_q2_x", int'(q2_x), 19);
    check("eq_q1_head", int'(q1_head), int'(LEFT));
    check("eq_q2_head", int'(q2_head), int'(RIGHT));
    check("c10_p1_x", int'(p1_x), 20);
    check("c10_p2_x", int'(p2_x), 19);
    check("c10_winner", int'(winner), 0);
    wait_step(n);
    check("swap_winner", int'(winner), 3);
    check("swap_running", int'(running), 0);
    check("swap_p1_x", int'(p1_x), 20);
    check("swap_p2_x", int'(p2_x), 19);
    check("swap_p1_y", int'(p1_y), 15);
    check("swap_p1_head", int'(p1_head), int'(LEFT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
